// File: rtl/exec_unit_pipelined.sv
// Registered execution stage: one-cycle ALU/shift ops and multi-cycle DMEM
// LOAD/STORE with ack timeout, valid/ready on both the issue and writeback sides.

package simple_processor_pkg;
    typedef enum logic [3:0] {
        FUNC_ADD   = 4'd0,
        FUNC_ADDI  = 4'd1,
        FUNC_SUB   = 4'd2,
        FUNC_AND   = 4'd3,
        FUNC_OR    = 4'd4,
        FUNC_XOR   = 4'd5,
        FUNC_NOT   = 4'd6,
        FUNC_SLL   = 4'd7,
        FUNC_SLR   = 4'd8,
        FUNC_SLLI  = 4'd9,
        FUNC_SLRI  = 4'd10,
        FUNC_LOAD  = 4'd11,
        FUNC_STORE = 4'd12
    } func_t;
endpackage

module exec_unit_pipelined
    import simple_processor_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int IMM_WIDTH      = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  func_t                     func_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [IMM_WIDTH-1:0]      imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                      dmem_req_o,
    output logic [DATA_WIDTH-1:0]     dmem_addr_o,
    output logic                      dmem_we_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    input  logic                      dmem_ack_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      rd_we_o,
    output logic                      err_o
);

    localparam int SH_W  = $clog2(DATA_WIDTH);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q,      state_d;
    logic [CNT_W-1:0]          cnt_q,        cnt_d;
    logic                      dmem_req_q,   dmem_req_d;
    logic [DATA_WIDTH-1:0]     dmem_addr_q,  dmem_addr_d;
    logic                      dmem_we_q,    dmem_we_d;
    logic [DATA_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;
    logic                      out_valid_q,  out_valid_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
    logic [DATA_WIDTH-1:0]     rd_data_q,    rd_data_d;
    logic                      rd_we_q,      rd_we_d;
    logic                      err_q,        err_d;

    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_known;
    logic                  is_mem_op;
    logic                  issue;
    logic                  timeout_hit;

    assign imm_ext   = {{(DATA_WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
    assign is_mem_op = (func_i == FUNC_LOAD) || (func_i == FUNC_STORE);

    assign in_ready_o = !rst_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
    assign issue      = in_valid_i && in_ready_o;

    // The timeout fires on the last allowed request cycle, so req stays high
    // for exactly MEM_TIMEOUT cycles.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // NOTE: every output of a combinational block gets a default up front;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        alu_result = '0;
        alu_known  = 1'b1;
        case (func_i)
            FUNC_ADD:  alu_result = rs1_data_i + rs2_data_i;
            FUNC_ADDI: alu_result = rs1_data_i + imm_ext;
            FUNC_SUB:  alu_result = rs1_data_i - rs2_data_i;
            FUNC_AND:  alu_result = rs1_data_i & rs2_data_i;
            FUNC_OR:   alu_result = rs1_data_i | rs2_data_i;
            FUNC_XOR:  alu_result = rs1_data_i ^ rs2_data_i;
            FUNC_NOT:  alu_result = ~rs1_data_i;
            FUNC_SLL:  alu_result = rs1_data_i << rs2_data_i[SH_W-1:0];
            FUNC_SLR:  alu_result = rs1_data_i >> rs2_data_i[SH_W-1:0];
            FUNC_SLLI: alu_result = rs1_data_i << imm_ext[SH_W-1:0];
            FUNC_SLRI: alu_result = rs1_data_i >> imm_ext[SH_W-1:0];
            default:   alu_known  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req_d   = dmem_req_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_we_d    = dmem_we_q;
        dmem_wdata_d = dmem_wdata_q;
        out_valid_d  = out_valid_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        rd_we_d      = rd_we_q;
        err_d        = err_q;

        case (state_q)
            MEM: begin
                if (dmem_ack_i) begin
                    state_d     = DONE;
                    dmem_req_d  = 1'b0;
                    out_valid_d = 1'b1;
                    rd_we_d     = !dmem_we_q;
                    rd_data_d   = dmem_we_q ? '0 : dmem_rdata_i;
                    err_d       = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    dmem_req_d  = 1'b0;
                    out_valid_d = 1'b1;
                    rd_we_d     = 1'b0;
                    rd_data_d   = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Issue is only possible from IDLE or a retiring DONE, so it overrides.
        if (issue) begin
            rd_addr_d = rd_addr_i;
            err_d     = 1'b0;
            if (is_mem_op) begin
                state_d      = MEM;
                cnt_d        = '0;
                dmem_req_d   = 1'b1;
                dmem_addr_d  = rs1_data_i + imm_ext;
                dmem_we_d    = (func_i == FUNC_STORE);
                dmem_wdata_d = (func_i == FUNC_STORE) ? rs2_data_i : '0;
                out_valid_d  = 1'b0;
            end else begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                rd_data_d   = alu_result;
                rd_we_d     = alu_known;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_we_q    <= 1'b0;
            dmem_wdata_q <= '0;
            out_valid_q  <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_we_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmem_req_q   <= dmem_req_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_we_q    <= dmem_we_d;
            dmem_wdata_q <= dmem_wdata_d;
            out_valid_q  <= out_valid_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_we_q      <= rd_we_d;
            err_q        <= err_d;
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign out_valid_o  = out_valid_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_data_o    = rd_data_q;
    assign rd_we_o      = rd_we_q;
    assign err_o        = err_q;

endmodule

// File: doc/exec_unit_pipelined.md
Name: exec_unit_pipelined

Overview:
- Parametrised, registered successor to the single-cycle execution merge stage. Sits between decode/register-read and writeback.
- Executes ALU math, gate, and shift ops in one registered cycle. Runs LOAD/STORE as a multi-cycle DMEM request/acknowledge transaction with timeout.
- Uses valid/ready handshakes on both the issue side and the writeback side.

Parameters:
- DATA_WIDTH, 32: datapath, register, and DMEM data/address width.
- IMM_WIDTH, 6: immediate width; sign-extended to DATA_WIDTH.
- REG_ADDR_WIDTH, 5: destination register index width.
- MEM_TIMEOUT, 16: maximum cycles waiting for dmem_ack_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  issue-side op valid
- in_ready_o  out  1  unit can accept an op this cycle
- func_i  in  func_t  operation (simple_processor_pkg)
- rs1_data_i  in  DATA_WIDTH  source register 1 data
- rs2_data_i  in  DATA_WIDTH  source register 2 data
- imm_i  in  IMM_WIDTH  immediate
- rd_addr_i  in  REG_ADDR_WIDTH  destination register index
- dmem_req_o  out  1  DMEM request active
- dmem_addr_o  out  DATA_WIDTH  DMEM address
- dmem_we_o  out  1  DMEM write enable (STORE)
- dmem_wdata_o  out  DATA_WIDTH  DMEM write data
- dmem_rdata_i  in  DATA_WIDTH  DMEM read data, valid with ack
- dmem_ack_i  in  1  DMEM transaction complete
- out_valid_o  out  1  result valid to writeback
- out_ready_i  in  1  writeback accepts result
- rd_addr_o  out  REG_ADDR_WIDTH  registered destination index
- rd_data_o  out  DATA_WIDTH  registered result
- rd_we_o  out  1  register-file write required
- err_o  out  1  DMEM timeout on this result

Behaviour:
- Clock and reset: single clock clk_i. Reset is rst_i, synchronous and active-high.
- Reset values: state=IDLE; every output 0, including in_ready_o while rst_i=1. Reset mid-transaction abandons it: dmem_req_o=0 and out_valid_o=0 in the cycle after rst_i is sampled.
- FSM states: IDLE, MEM, DONE.
- Issue acceptance: in_ready_o = !rst_i && (state==IDLE || (state==DONE && out_ready_i)). Issue fires when in_valid_i && in_ready_o.
- Issue of ALU op or unknown func: go to DONE with outputs registered. out_valid_o=1 the next cycle (latency 1).
- Issue of LOAD/STORE: go to MEM. Register dmem_addr_o = rs1 + sext(imm), dmem_we_o = (STORE), dmem_wdata_o = rs2 (STORE only, else 0).
- MEM state:
  - dmem_req_o=1; address, we, and wdata held stable.
  - On dmem_ack_i: go to DONE, dmem_req_o=0 next cycle, LOAD captures dmem_rdata_i into rd_data_o.
  - Ack in the first MEM cycle is legal, giving minimum load latency 2 (issue T, req/ack T+1, out_valid T+2).
- Timeout (MEM_TIMEOUT≠0): a counter clears on MEM entry and increments each MEM cycle without ack. If no ack after MEM_TIMEOUT req cycles: go to DONE with err_o=1, rd_we_o=0, rd_data_o=0, and drop req.
- Ack outside MEM is ignored.
- DONE state: out_valid_o=1; rd_* and err_o held stable while !out_ready_i.
  - out_ready_i with a new issue: go to the new op's state (back-to-back ALU ops give 1 result/cycle).
  - out_ready_i without issue: go to IDLE, out_valid_o=0.
- Arithmetic (all results wrap modulo 2^DATA_WIDTH):
  - ADD = rs1+rs2; ADDI = rs1+sext(imm); SUB = rs1-rs2.
  - AND/OR/XOR = bitwise with rs2; NOT = ~rs1.
  - SLL/SLR use rs2; SLLI/SLRI use sext(imm). Shifts are logical, with amount = low $clog2(DATA_WIDTH) bits.
- rd_we_o: 1 for all ALU ops and for a successful LOAD; 0 for STORE, unknown func, and timeout. STORE and unknown func still produce one out_valid_o beat with rd_data_o=0.
- rd_addr_o: rd_addr_i registered at issue.
- err_o: 0 except on a timeout result; it clears with the next result.

Test Plan:
- ADDI rs1=5, imm=6'b111110 -> cycle+1: out_valid_o=1, rd_data_o=3, rd_we_o=1, err_o=0.
- SUB rs1=0, rs2=1, then AND 0xF0F0_F0F0 & 0x0FF0_0FF0 back-to-back with out_ready_i=1 -> results 0xFFFF_FFFF, then 0x00F0_00F0 on consecutive cycles; in_ready_o stays 1.
- SLLI rs1=1, imm=33 -> rd_data_o=2 (amount 33 mod 32 = 1). SLR rs1=0x8000_0000, rs2=31 -> 1.
- LOAD rs1=0x100, imm=4, ack 3 cycles after req with rdata 0xDEAD_BEEF -> dmem_req_o high 3 cycles, addr 0x104, dmem_we_o=0. out_valid_o the cycle after ack, rd_data_o=0xDEAD_BEEF, rd_we_o=1.
- STORE rs1=0x20, rs2=0x55 with MEM_TIMEOUT=8 and no ack -> req high exactly 8 cycles, wdata 0x55, dmem_we_o=1. Then out_valid_o=1, err_o=1, rd_we_o=0.
- ADD result with out_ready_i=0 for 4 cycles -> rd_data_o stable and in_ready_o=0. Then LOAD issue; assert rst_i during MEM -> next cycle dmem_req_o=0, out_valid_o=0, in_ready_o=0, state IDLE.
